jzjpcc_mmio_bank: RTL
=====================

Name: jzjpcc_mmio_bank

Overview:
Parametrised memory-mapped IO bank for the jzjpcc core. It is the successor to the fixed 8-in/8-out MMIO window, and is attached to the memory stage's data backend.
- Adds a configurable port count and base address.
- Adds byte-enable writes and per-port direction registers.
- Adds input synchronisers, sticky per-bit change flags (write-1-to-clear) and a maskable interrupt line.
- Decodes its own address range; asserts hit so the backend can mux read data.

Parameters:
NUM_PORTS, 8, number of 32-bit IO ports; power of two, 1..16.
BASE_ADDR, 32'hFFFFFF00, byte base of the region; aligned to region size (32*NUM_PORTS bytes).
SYNC_STAGES, 2, flip-flop stages on each mmioInputs bit; 1..3.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  synchronous, active-high.
busAddr  input  30  word address [31:2].
busWriteData  input  32  write data.
busByteEnable  input  4  byte lanes for writes.
busWrite  input  1  write strobe, single cycle.
busRead  input  1  read strobe, single cycle.
busHit  output  1  combinational: busAddr lies within the region.
busReadData  output  32  registered read data.
busReadValid  output  1  high the cycle after an accepted read.
mmioInputs  input  32 x NUM_PORTS  asynchronous external inputs.
mmioOutputs  output  32 x NUM_PORTS  output registers.
mmioDirection  output  32 x NUM_PORTS  direction registers; 1 = drive.
irq  output  1  registered: OR over ports of (flags & irqEnable).

Behaviour:
- Address decode:
  - offset = busAddr - BASE_ADDR[31:2]; hit when offset < 8*NUM_PORTS.
  - bank = offset / NUM_PORTS; port = offset % NUM_PORTS.
- Banks:
  - 0: data-out, RW.
  - 1: data-in (synchronised value), RO; writes ignored.
  - 2: direction, RW.
  - 3: change flags, W1C.
  - 4: irqEnable, RW.
  - 5-7: reserved; read 0, writes ignored.
- Writes take effect on the clock edge of the strobe cycle. Only lanes with busByteEnable set are affected.
  - RW banks: the enabled bytes are replaced.
  - Bank 3: flag bits clear where the enabled wdata bit = 1.
- Reads:
  - busReadData and busReadValid are registered; latency is exactly 1 cycle.
  - The value returned is the register's value before any same-cycle write or flag set takes effect.
  - Reads have no side effects.
  - A read or write with busHit=0 is ignored; busReadValid stays 0 and busReadData holds its value.
  - busRead and busWrite both high: both are serviced; the read returns the old value.
- Input path: mmioInputs pass through a SYNC_STAGES-deep chain to syncIn; a prev register holds syncIn delayed 1 cycle.
- Change detect:
  - flag bit sets when syncIn != prev (either edge).
  - Set and clear in the same cycle: set wins.
- Warm-up:
  - A counter suppresses flag setting for SYNC_STAGES+1 cycles after reset deassertion, so reset-to-input transitions are never flagged.
  - Counter saturates; flags are enabled from cycle SYNC_STAGES+2 onward.
- Interrupt: irq is registered, so it lags flag changes by 1 cycle. It stays high until every enabled flag is cleared or masked.
- Reset values (on reset=1 at a clock edge): all of the following are 0:
  - mmioOutputs, mmioDirection, flags, irqEnable
  - sync chain, prev
  - busReadData, busReadValid, irq
  - warm-up counter
- Reset mid-operation: a read accepted in the reset cycle is dropped (busReadValid=0 next cycle); pending flags are lost.

Decomposition:
- Package jzjpcc_mmio_pkg holds:
  - bank index enum (BANK_OUT, BANK_IN, BANK_DIR, BANK_FLAG, BANK_IRQEN).
  - BANKS=8 constant.
  - byte-lane merge function (old, new, byteEnable).
- Sub-module jzjpcc_mmio_sync: one instance per port. It contains the SYNC_STAGES chain, the prev register and the change vector. The warm-up gate is applied in the parent.

Test Plan:
- Reset, then write 0xDEADBEEF with byteEnable 4'b0101 to port 3, bank 0 (addr 0xFFFFFF0C) → mmioOutputs[3] = 0x00AD00EF. A read of the same address the next cycle gives busReadValid=1 and 0x00AD00EF one cycle later.
- Hold mmioInputs[5]=0x0000FFFF through reset → after warm-up, flags[5]=0 and bank-1 read returns 0x0000FFFF. Then drive 0x0000FFF0 → flags[5]=0x0000000F exactly SYNC_STAGES+1 cycles after the change.
- Set irqEnable[5]=0x1 with flag bit 0 set → irq=1. W1C 0x1 to flags[5] → irq=0 one cycle after the flag clears.
- Toggle an input bit in the same cycle as a W1C of that bit → the flag remains 1.
- Read at BASE_ADDR+0x100 (out of range) → busHit=0 and busReadValid=0. Read of bank 6 → returns 0.
- Assert reset during a read cycle → busReadValid=0 next cycle; all outputs 0.

Source files
------------

// File: rtl/jzjpcc_mmio_pkg.sv
// rtl/jzjpcc_mmio_pkg.sv - shared bank indices, constants and byte-lane helpers for the MMIO bank
package jzjpcc_mmio_pkg;

  localparam int BANKS = 8;

  typedef enum logic [2:0] {
    BANK_OUT   = 3'd0,
    BANK_IN    = 3'd1,
    BANK_DIR   = 3'd2,
    BANK_FLAG  = 3'd3,
    BANK_IRQEN = 3'd4
  } bank_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] byte_en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{byte_en[i]}};
    return m;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byte_en);
    logic [31:0] m;
    m = lane_mask(byte_en);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/jzjpcc_mmio_sync.sv
// rtl/jzjpcc_mmio_sync.sv - per-port input synchroniser with one-cycle history and change vector
module jzjpcc_mmio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] async_i,
  output logic [31:0] sync_o,
  output logic [31:0] change_o
);

  logic [SYNC_STAGES-1:0][31:0] chain_q;
  logic [31:0]                  prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o   = chain_q[SYNC_STAGES-1];
  assign change_o = sync_o ^ prev_q;

endmodule

// File: rtl/jzjpcc_mmio_bank.sv
// rtl/jzjpcc_mmio_bank.sv - parametrised MMIO bank: out/in/dir/flag/irqEnable registers on the data backend
module jzjpcc_mmio_bank
  import jzjpcc_mmio_pkg::*;
#(
  parameter int          NUM_PORTS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [29:0]                busAddr,
  input  logic [31:0]                busWriteData,
  input  logic [3:0]                 busByteEnable,
  input  logic                       busWrite,
  input  logic                       busRead,
  output logic                       busHit,
  output logic [31:0]                busReadData,
  output logic                       busReadValid,
  input  logic [NUM_PORTS-1:0][31:0] mmioInputs,
  output logic [NUM_PORTS-1:0][31:0] mmioOutputs,
  output logic [NUM_PORTS-1:0][31:0] mmioDirection,
  output logic                       irq
);

  localparam int                PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [29:0]       BASE_WORD    = BASE_ADDR[31:2];
  localparam logic [29:0]       REGION_WORDS = 30'(BANKS * NUM_PORTS);
  localparam int                WARM_W       = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE    = WARM_W'(SYNC_STAGES + 1);

  logic [29:0]       offset;
  logic [2:0]        bank_idx;
  logic [PORT_W-1:0] port_idx;

  logic [NUM_PORTS-1:0][31:0] out_q, out_d, dir_q, dir_d;
  logic [NUM_PORTS-1:0][31:0] flag_q, flag_d, ien_q, ien_d;
  logic [NUM_PORTS-1:0][31:0] sync_in, change;
  logic [31:0]                rdata_q, rd_val;
  logic                       rvalid_q, irq_q, irq_d;
  logic [WARM_W-1:0]          warm_q, warm_d;

  assign offset   = busAddr - BASE_WORD;
  assign busHit   = offset < REGION_WORDS;
  assign bank_idx = 3'(offset / 30'(NUM_PORTS));
  assign port_idx = PORT_W'(offset % 30'(NUM_PORTS));

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    jzjpcc_mmio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_i  (mmioInputs[p]),
      .sync_o   (sync_in[p]),
      .change_o (change[p])
    );
  end

  always_comb begin
    rd_val = '0;
    case (bank_e'(bank_idx))
      BANK_OUT:   rd_val = out_q[port_idx];
      BANK_IN:    rd_val = sync_in[port_idx];
      BANK_DIR:   rd_val = dir_q[port_idx];
      BANK_FLAG:  rd_val = flag_q[port_idx];
      BANK_IRQEN: rd_val = ien_q[port_idx];
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    flag_d = flag_q;
    if (busWrite && busHit) begin
      case (bank_e'(bank_idx))
        BANK_OUT:   out_d[port_idx] = byte_merge(out_q[port_idx], busWriteData, busByteEnable);
        BANK_DIR:   dir_d[port_idx] = byte_merge(dir_q[port_idx], busWriteData, busByteEnable);
        BANK_IRQEN: ien_d[port_idx] = byte_merge(ien_q[port_idx], busWriteData, busByteEnable);
        BANK_FLAG:  flag_d[port_idx] = flag_q[port_idx] & ~(busWriteData & lane_mask(busByteEnable));
        default:    ;
      endcase
    end
    // Set is applied after the W1C so a same-cycle edge keeps its flag.
    if (warm_q == WARM_DONE) flag_d = flag_d | change;
    warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + 1'b1;
    irq_d  = |(flag_q & ien_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      flag_q   <= '0;
      ien_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      warm_q   <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      flag_q   <= flag_d;
      ien_q    <= ien_d;
      rvalid_q <= busRead && busHit;
      if (busRead && busHit) rdata_q <= rd_val;
      irq_q    <= irq_d;
      warm_q   <= warm_d;
    end
  end

  assign mmioOutputs   = out_q;
  assign mmioDirection = dir_q;
  assign busReadData   = rdata_q;
  assign busReadValid  = rvalid_q;
  assign irq           = irq_q;

endmodule
